// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm
// Moore sequencer for the multicycle MIPS-subset datapath. It steps one
// instruction through fetch / decode / execute / memory / writeback, waits on
// the memory-ready handshake, traps illegal opcodes and counts retired
// instructions.
// Optional feature macro: CTRL_JUMP_EN (enables the JUMP state for opcode 0x02).
module multicycle_control_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic [3:0]       state_out,
  output logic             illegal_op,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'h0,
    S_DECODE   = 4'h1,
    S_MEM_ADDR = 4'h2,
    S_MEM_RD   = 4'h3,
    S_MEM_WB   = 4'h4,
    S_MEM_WR   = 4'h5,
    S_EXEC_R   = 4'h6,
    S_R_WB     = 4'h7,
    S_BRANCH   = 4'h8,
    S_ADDI_EX  = 4'h9,
    S_ADDI_WB  = 4'hA,
`ifdef CTRL_JUMP_EN
    S_JUMP     = 4'hB,
`endif
    S_TRAP     = 4'hF
  } state_t;

  // Registered control word; 'fetch' marks the state whose ir_write/pc_write
  // are qualified by mem_ready outside the register.
  typedef struct packed {
    logic       fetch;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;
  } ctrl_t;

  // Moore decode of a state into its datapath control word.
  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.fetch = 1'b1; c.mem_read = 1'b1; c.alu_src_b = 2'b01;
      end
      S_DECODE:   c.alu_src_b = 2'b11;
      S_MEM_ADDR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_MEM_RD:   begin c.mem_read = 1'b1; c.i_or_d = 1'b1; end
      S_MEM_WB:   begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
      S_MEM_WR:   begin c.mem_write = 1'b1; c.i_or_d = 1'b1; end
      S_EXEC_R:   begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
      S_R_WB:     begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
      S_BRANCH: begin
        c.alu_src_a = 1'b1; c.alu_op = 2'b01;
        c.pc_write_cond = 1'b1; c.pc_source = 2'b01;
      end
      S_ADDI_EX:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_ADDI_WB:  c.reg_write = 1'b1;
`ifdef CTRL_JUMP_EN
      S_JUMP:     begin c.pc_write = 1'b1; c.pc_source = 2'b10; end
`endif
      S_TRAP:     c.illegal = 1'b1;
      default:    c.illegal = 1'b1;
    endcase
    return c;
  endfunction

  // Next-state rules; any unexpected code or opcode lands in TRAP.
  function automatic state_t next_state(input state_t s, input logic [5:0] op,
                                        input logic rdy);
    state_t n;
    n = S_TRAP;
    case (s)
      S_FETCH:  n = rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          6'h23, 6'h2B: n = S_MEM_ADDR;
          6'h00:        n = S_EXEC_R;
          6'h04:        n = S_BRANCH;
          6'h08:        n = S_ADDI_EX;
`ifdef CTRL_JUMP_EN
          6'h02:        n = S_JUMP;
`endif
          default:      n = S_TRAP;
        endcase
      end
      S_MEM_ADDR: begin
        case (op)
          6'h23:   n = S_MEM_RD;
          6'h2B:   n = S_MEM_WR;
          default: n = S_TRAP;
        endcase
      end
      S_MEM_RD:  n = rdy ? S_MEM_WB : S_MEM_RD;
      S_MEM_WB:  n = S_FETCH;
      S_MEM_WR:  n = rdy ? S_FETCH : S_MEM_WR;
      S_EXEC_R:  n = S_R_WB;
      S_R_WB:    n = S_FETCH;
      S_BRANCH:  n = S_FETCH;
      S_ADDI_EX: n = S_ADDI_WB;
      S_ADDI_WB: n = S_FETCH;
`ifdef CTRL_JUMP_EN
      S_JUMP:    n = S_FETCH;
`endif
      S_TRAP:    n = S_TRAP;
      default:   n = S_TRAP;
    endcase
    return n;
  endfunction

  state_t           r_state;
  ctrl_t            r_ctrl;
  logic [CNT_W-1:0] r_retired;
  state_t           w_next;

  assign w_next = next_state(r_state, opcode, mem_ready);

  // State, registered control word and retired counter; a return to FETCH
  // from any other state marks one completed instruction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_FETCH;
      r_ctrl    <= decode(S_FETCH);
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      r_ctrl  <= decode(w_next);
      if ((w_next == S_FETCH) && (r_state != S_FETCH)) begin
        r_retired <= r_retired + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Write enables are held off while reset is low; fetch-time loads wait for
  // the memory handshake.
  assign pc_write      = rst & (r_ctrl.fetch ? mem_ready : r_ctrl.pc_write);
  assign ir_write      = rst & r_ctrl.fetch & mem_ready;
  assign pc_write_cond = rst & r_ctrl.pc_write_cond;
  assign reg_write     = rst & r_ctrl.reg_write;
  assign mem_write     = rst & r_ctrl.mem_write;
  assign i_or_d        = r_ctrl.i_or_d;
  assign mem_read      = r_ctrl.mem_read;
  assign mem_to_reg    = r_ctrl.mem_to_reg;
  assign reg_dst       = r_ctrl.reg_dst;
  assign alu_src_a     = r_ctrl.alu_src_a;
  assign alu_src_b     = r_ctrl.alu_src_b;
  assign alu_op        = r_ctrl.alu_op;
  assign pc_source     = r_ctrl.pc_source;
  assign illegal_op    = r_ctrl.illegal;
  assign state_out     = r_state;
  assign retired       = r_retired;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: randomized instruction
// streams compared cycle by cycle against a per-instruction state-sequence
// model. A second instance with a 4-bit counter shares all inputs.
module tb_multicycle_control_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  opcode = 6'h00;
  logic        mem_ready = 1'b0;

  logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic        mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic [3:0]  state_out;
  logic [31:0] retired;

  logic        w_pc_write, w_pc_write_cond, w_i_or_d, w_mem_read, w_mem_write, w_ir_write;
  logic        w_mem_to_reg, w_reg_dst, w_reg_write, w_alu_src_a, w_illegal_op;
  logic [1:0]  w_alu_src_b, w_alu_op, w_pc_source;
  logic [3:0]  w_state_out;
  logic [3:0]  w_retired;

  int          total = 0;
  int          bad = 0;
  logic [31:0] model_ret = 32'd0;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .state_out(state_out), .illegal_op(illegal_op),
    .retired(retired)
  );

  multicycle_control_fsm #(.CNT_W(4)) u_dut_w (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(w_pc_write), .pc_write_cond(w_pc_write_cond), .i_or_d(w_i_or_d),
    .mem_read(w_mem_read), .mem_write(w_mem_write), .ir_write(w_ir_write),
    .mem_to_reg(w_mem_to_reg), .reg_dst(w_reg_dst), .reg_write(w_reg_write),
    .alu_src_a(w_alu_src_a), .alu_src_b(w_alu_src_b), .alu_op(w_alu_op),
    .pc_source(w_pc_source), .state_out(w_state_out), .illegal_op(w_illegal_op),
    .retired(w_retired)
  );

  logic [16:0] act, act_w;
  assign act = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                pc_source, illegal_op};
  assign act_w = {w_pc_write, w_pc_write_cond, w_i_or_d, w_mem_read, w_mem_write,
                  w_ir_write, w_mem_to_reg, w_reg_dst, w_reg_write, w_alu_src_a,
                  w_alu_src_b, w_alu_op, w_pc_source, w_illegal_op};

  // Expected control outputs for a state code, straight from the state table.
  function automatic logic [16:0] exp_ctrl(input int st, input logic mr, input logic rs);
    logic pw, pwc, ior, mrd, mwr, irw, m2r, rd, rw, asa, ill;
    logic [1:0] asb, aop, psrc;
    pw = 1'b0; pwc = 1'b0; ior = 1'b0; mrd = 1'b0; mwr = 1'b0; irw = 1'b0;
    m2r = 1'b0; rd = 1'b0; rw = 1'b0; asa = 1'b0; ill = 1'b0;
    asb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (st)
      0:  begin pw = mr; mrd = 1'b1; irw = mr; asb = 2'b01; end
      1:  asb = 2'b11;
      2:  begin asa = 1'b1; asb = 2'b10; end
      3:  begin mrd = 1'b1; ior = 1'b1; end
      4:  begin rw = 1'b1; m2r = 1'b1; end
      5:  begin mwr = 1'b1; ior = 1'b1; end
      6:  begin asa = 1'b1; aop = 2'b10; end
      7:  begin rw = 1'b1; rd = 1'b1; end
      8:  begin asa = 1'b1; aop = 2'b01; pwc = 1'b1; psrc = 2'b01; end
      9:  begin asa = 1'b1; asb = 2'b10; end
      10: rw = 1'b1;
      11: begin pw = 1'b1; psrc = 2'b10; end
      15: ill = 1'b1;
      default: ill = 1'b1;
    endcase
    if (!rs) begin pw = 1'b0; pwc = 1'b0; irw = 1'b0; rw = 1'b0; mwr = 1'b0; end
    return {pw, pwc, ior, mrd, mwr, irw, m2r, rd, rw, asa, asb, aop, psrc, ill};
  endfunction

  function automatic logic [5:0] pick_op();
    int k;
`ifdef CTRL_JUMP_EN
    k = $urandom_range(0, 5);
`else
    k = $urandom_range(0, 4);
`endif
    case (k)
      0: return 6'h23;
      1: return 6'h2B;
      2: return 6'h00;
      3: return 6'h04;
      4: return 6'h08;
      default: return 6'h02;
    endcase
  endfunction

  // Run one instruction: build its expected state sequence (with wait states)
  // and compare every cycle, then check the return to FETCH and the counter.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
    int   st_q[$];
    logic mr_q[$];
    logic trap;
    trap = 1'b0;
    for (int i = 0; i < fw; i++) begin st_q.push_back(0); mr_q.push_back(1'b0); end
    st_q.push_back(0); mr_q.push_back(1'b1);
    st_q.push_back(1); mr_q.push_back(1'($urandom));
    case (op)
      6'h23: begin
        st_q.push_back(2); mr_q.push_back(1'($urandom));
        for (int i = 0; i < mw; i++) begin st_q.push_back(3); mr_q.push_back(1'b0); end
        st_q.push_back(3); mr_q.push_back(1'b1);
        st_q.push_back(4); mr_q.push_back(1'($urandom));
      end
      6'h2B: begin
        st_q.push_back(2); mr_q.push_back(1'($urandom));
        for (int i = 0; i < mw; i++) begin st_q.push_back(5); mr_q.push_back(1'b0); end
        st_q.push_back(5); mr_q.push_back(1'b1);
      end
      6'h00: begin
        st_q.push_back(6); mr_q.push_back(1'($urandom));
        st_q.push_back(7); mr_q.push_back(1'($urandom));
      end
      6'h04: begin st_q.push_back(8); mr_q.push_back(1'($urandom)); end
      6'h08: begin
        st_q.push_back(9);  mr_q.push_back(1'($urandom));
        st_q.push_back(10); mr_q.push_back(1'($urandom));
      end
`ifdef CTRL_JUMP_EN
      6'h02: begin st_q.push_back(11); mr_q.push_back(1'($urandom)); end
`endif
      default: begin st_q.push_back(15); mr_q.push_back(1'($urandom)); trap = 1'b1; end
    endcase
    for (int i = 0; i < st_q.size(); i++) begin
      @(negedge clk);
      opcode = op; mem_ready = mr_q[i];
      #1;
      total++;
      if (state_out !== 4'(st_q[i]) || w_state_out !== 4'(st_q[i])) begin
        bad++;
        $display("FAIL state op=%h step=%0d got=%h/%h exp=%h", op, i, state_out, w_state_out, st_q[i]);
      end
      total++;
      if (act !== exp_ctrl(st_q[i], mr_q[i], 1'b1) || act_w !== exp_ctrl(st_q[i], mr_q[i], 1'b1)) begin
        bad++;
        $display("FAIL ctrl op=%h step=%0d st=%h got=%h/%h exp=%h", op, i, st_q[i], act, act_w,
                 exp_ctrl(st_q[i], mr_q[i], 1'b1));
      end
    end
    if (!trap) begin
      @(posedge clk); #1;
      model_ret = model_ret + 32'd1;
      total++;
      if (state_out !== 4'h0 || retired !== model_ret || w_retired !== model_ret[3:0]) begin
        bad++;
        $display("FAIL retire op=%h got st=%h ret=%0d/%0d exp ret=%0d", op, state_out, retired,
                 w_retired, model_ret);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0; mem_ready = 1'b1; opcode = 6'($urandom);
    #1;
    model_ret = 32'd0;
    total++;
    if (state_out !== 4'h0 || retired !== 32'd0 || w_retired !== 4'd0 || illegal_op !== 1'b0) begin
      bad++;
      $display("FAIL reset_state got st=%h ret=%0d ill=%b exp st=0 ret=0 ill=0", state_out, retired, illegal_op);
    end
    total++;
    if (act !== exp_ctrl(0, 1'b1, 1'b0)) begin
      bad++;
      $display("FAIL reset_ctrl got=%h exp=%h", act, exp_ctrl(0, 1'b1, 1'b0));
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1; mem_ready = 1'b0;
    @(posedge clk); #1;
    total++;
    if (state_out !== 4'h0 || retired !== 32'd0) begin
      bad++;
      $display("FAIL reset_release got st=%h ret=%0d exp st=0 ret=0", state_out, retired);
    end
  endtask

  task automatic test_directed();
    run_instr(6'h00, 0, 0);   // 0,1,6,7
    run_instr(6'h23, 0, 2);   // lw, 7 cycles
    run_instr(6'h2B, 0, 0);   // sw, 4 cycles
    run_instr(6'h04, 0, 0);   // beq, 3 cycles
    run_instr(6'h08, 1, 0);   // addi with a fetch wait
    run_instr(6'h2B, 2, 1);   // sw with waits
  endtask

  task automatic test_jump();
`ifdef CTRL_JUMP_EN
    run_instr(6'h02, 0, 0);
`else
    run_instr(6'h02, 0, 0);
    @(negedge clk); #1;
    total++;
    if (state_out !== 4'hF || illegal_op !== 1'b1) begin
      bad++;
      $display("FAIL jump_trap got st=%h ill=%b exp st=f ill=1", state_out, illegal_op);
    end
    test_reset();
`endif
  endtask

  task automatic test_trap();
    run_instr(6'h3F, $urandom_range(0, 1), 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      opcode = 6'($urandom); mem_ready = 1'($urandom);
      #1;
      total++;
      if (state_out !== 4'hF || act !== exp_ctrl(15, mem_ready, 1'b1) ||
          retired !== model_ret || w_retired !== model_ret[3:0]) begin
        bad++;
        $display("FAIL trap_hold cyc=%0d got st=%h ctrl=%h ret=%0d exp st=f ctrl=%h ret=%0d",
                 i, state_out, act, retired, exp_ctrl(15, mem_ready, 1'b1), model_ret);
      end
    end
    test_reset();
  endtask

  task automatic test_reset_mid();
    int seq[4] = '{0, 1, 2, 3};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      opcode = 6'h23; mem_ready = 1'b1;
      #1;
      total++;
      if (state_out !== 4'(seq[i])) begin
        bad++;
        $display("FAIL mid_seq step=%0d got=%h exp=%h", i, state_out, seq[i]);
      end
    end
    @(negedge clk);
    mem_ready = 1'($urandom);
    #1;
    total++;
    if (state_out !== 4'h4 || reg_write !== 1'b1) begin
      bad++;
      $display("FAIL mid_wb got st=%h rw=%b exp st=4 rw=1", state_out, reg_write);
    end
    rst = 1'b0;
    #1;
    model_ret = 32'd0;
    total++;
    if (reg_write !== 1'b0 || state_out !== 4'h0 || retired !== 32'd0 || w_reg_write !== 1'b0) begin
      bad++;
      $display("FAIL mid_abort got rw=%b st=%h ret=%0d exp rw=0 st=0 ret=0", reg_write, state_out, retired);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1; mem_ready = 1'b0;
    @(posedge clk); #1;
    total++;
    if (state_out !== 4'h0 || reg_write !== 1'b0 || retired !== 32'd0) begin
      bad++;
      $display("FAIL mid_after got st=%h rw=%b ret=%0d exp st=0 rw=0 ret=0", state_out, reg_write, retired);
    end
  endtask

  task automatic test_wrap();
    test_reset();
    for (int i = 0; i < 16; i++) run_instr(pick_op(), 0, 0);
    total++;
    if (w_retired !== 4'd0 || retired !== 32'd16) begin
      bad++;
      $display("FAIL wrap got ret4=%0d ret32=%0d exp ret4=0 ret32=16", w_retired, retired);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) run_instr(pick_op(), $urandom_range(0, 2), $urandom_range(0, 2));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_directed();
    test_jump();
    test_trap();
    test_reset_mid();
    test_wrap();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) run_instr(6'h04, 0, 0);
  endtask

endmodule
